// File: rtl/sigmoid_scheduler_pkg.sv
// Shared types and constants for the sigmoid lookup scheduler.
// data_type is the signed fixed-point word used on every data port.
package sigmoid_scheduler_pkg;

    localparam int DATA_W               = 32;
    localparam int SIGMOID_DECIMAL_BITS = 12;
    localparam int EXTRA_BITS           = 4;

    typedef logic signed [DATA_W-1:0] data_type;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Largest LUT address magnitude; inputs beyond it saturate the sigmoid anyway.
    function automatic data_type max_mag(input int extra_bits, input int dec_bits);
        longint one_wide;
        one_wide = 1;
        return data_type'((one_wide << (extra_bits + dec_bits)) - 1);
    endfunction

endpackage

// File: rtl/sigmoid_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins,
// otherwise the lowest-numbered requester below it.
module sigmoid_scheduler_rr_arbiter
    import sigmoid_scheduler_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic [NREQ-1:0] hi_req;

    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(ptr_i)) begin
                hi_req[i] = req_i[i];
            end
        end
    end

    // Descending scans so the lowest eligible index is the one left standing.
    always_comb begin
        grant_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
        if (|hi_req) begin
            grant_o = '0;
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (hi_req[i]) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Time-shares one fixed-latency sigmoid LUT between NREQ vector requesters.
//   state    | meaning
//   IDLE     | arbitrate, capture granted vector on accept
//   ISSUE    | stream one |z| per cycle into the LUT, sign into the pipe
//   DRAIN    | no new lookups, wait for the last LUT return
//   RESP     | hold result vector and owner id until rsp_ready
module sigmoid_scheduler
    import sigmoid_scheduler_pkg::*;
#(
    parameter int M                    = 5,
    parameter int NREQ                 = 2,
    parameter int EXTRA_BITS           = sigmoid_scheduler_pkg::EXTRA_BITS,
    parameter int SIGMOID_DECIMAL_BITS = sigmoid_scheduler_pkg::SIGMOID_DECIMAL_BITS,
    parameter int LUT_LAT              = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  data_type                  req_z [NREQ][M],
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output data_type                  rsp_a [M],
    output logic                      lut_valid,
    output data_type                  lut_z,
    input  data_type                  lut_a,
    output logic                      busy
);

    localparam int       PW      = $clog2(NREQ);
    localparam int       IW      = (M > 1) ? $clog2(M) : 1;
    localparam data_type MAX_MAG = max_mag(EXTRA_BITS, SIGMOID_DECIMAL_BITS);
    localparam data_type SIG_ONE = data_type'(longint'(1) << SIGMOID_DECIMAL_BITS);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [IW-1:0] idx_q, idx_d;
    data_type      z_buf_q [M];
    data_type      z_buf_d [M];
    data_type      a_buf_q [M];
    data_type      a_buf_d [M];

    logic [LUT_LAT-1:0] vld_q, vld_d;
    logic [LUT_LAT-1:0] neg_q, neg_d;
    logic [IW-1:0]      pidx_q [LUT_LAT];
    logic [IW-1:0]      pidx_d [LUT_LAT];

    logic [NREQ-1:0]     grant;
    logic [PW-1:0]       gidx;
    logic                accept;
    logic                issuing;
    data_type            cur_z;
    logic signed [DATA_W:0] z_wide;
    logic signed [DATA_W:0] mag_wide;
    data_type            mag_c;
    logic                ret_vld;
    logic                ret_neg;
    logic [IW-1:0]       ret_idx;
    data_type            a_corr;

    sigmoid_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign issuing   = (state_q == ST_ISSUE);

    // Magnitude is formed one bit wider so the most-negative word clamps cleanly.
    always_comb begin
        cur_z    = z_buf_q[idx_q];
        z_wide   = {cur_z[DATA_W-1], cur_z};
        mag_wide = cur_z[DATA_W-1] ? -z_wide : z_wide;
        if (mag_wide > $signed({1'b0, MAX_MAG})) begin
            mag_c = MAX_MAG;
        end else begin
            mag_c = data_type'(mag_wide[DATA_W-1:0]);
        end
    end

    assign lut_valid = issuing;
    assign lut_z     = issuing ? mag_c : '0;

    assign ret_vld = vld_q[LUT_LAT-1];
    assign ret_neg = neg_q[LUT_LAT-1];
    assign ret_idx = pidx_q[LUT_LAT-1];
    assign a_corr  = ret_neg ? (SIG_ONE - lut_a) : lut_a;

    always_comb begin
        vld_d[0]  = issuing;
        neg_d[0]  = cur_z[DATA_W-1];
        pidx_d[0] = idx_q;
        for (int i = 1; i < LUT_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            neg_d[i]  = neg_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
    end

    always_comb begin
        a_buf_d = a_buf_q;
        if (ret_vld) begin
            a_buf_d[ret_idx] = a_corr;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        idx_d    = idx_q;
        z_buf_d  = z_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ISSUE;
                    idx_d    = '0;
                    owner_d  = gidx;
                    rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                    for (int i = 0; i < M; i++) begin
                        z_buf_d[i] = req_z[gidx][i];
                    end
                end
            end
            ST_ISSUE: begin
                if (idx_q == IW'(M - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                if (ret_vld && ret_idx == IW'(M - 1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            idx_q    <= '0;
            vld_q    <= '0;
            neg_q    <= '0;
            for (int i = 0; i < M; i++) begin
                z_buf_q[i] <= '0;
                a_buf_q[i] <= '0;
            end
            for (int i = 0; i < LUT_LAT; i++) begin
                pidx_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            neg_q    <= neg_d;
            z_buf_q  <= z_buf_d;
            a_buf_q  <= a_buf_d;
            pidx_q   <= pidx_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = owner_q;
    assign rsp_a     = a_buf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
